// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one imem request at a time and holds the
// returned word in a single-entry valid/ready buffer for decode, with redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        consume;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_REQ;
      fetch_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    consume       = instr_valid_q && instr_ready && !redirect_valid;

    if (redirect_valid) begin
      // A response arriving alongside a redirect belongs to the old path and is dropped.
      fetch_pc_d    = redirect_pc & 32'hFFFF_FFFC;
      instr_valid_d = 1'b0;
      if (state_q == ST_WAIT) state_d = ST_DRAIN;
    end else begin
      if (consume) instr_valid_d = 1'b0;
      case (state_q)
        ST_REQ: begin
          if (imem_req && imem_gnt) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_d       = imem_rdata;
            instr_pc_d    = fetch_pc_q;
            instr_valid_d = 1'b1;
            fetch_pc_d    = fetch_pc_q + 32'd4;
            state_d       = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req    = !reset && (state_q == ST_REQ) && !redirect_valid &&
                  (!instr_valid_q || instr_ready);
    imem_addr   = fetch_pc_q;
    instr_valid = instr_valid_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-computed addresses, data and handshake
// values driven one cycle at a time.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant one request at exp_addr; afterwards the sequencer sits in WAIT.
  task automatic issue(input string tag, input logic [31:0] exp_addr);
    imem_gnt = 1'b1;
    #1;
    check({tag, ".req"}, {31'b0, imem_req}, 32'd1);
    check({tag, ".addr"}, imem_addr, exp_addr);
    tick();
    imem_gnt = 1'b0;
    check({tag, ".wait_noreq"}, {31'b0, imem_req}, 32'd0);
  endtask

  task automatic respond(input logic [31:0] data);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic fetch_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    issue(tag, exp_addr);
    respond(data);
    check({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, ".instr"}, instr, data);
    check({tag, ".pc"}, instr_pc, exp_addr);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    #2;
    check("rst.req", {31'b0, imem_req}, 32'd0);
    check("rst.valid", {31'b0, instr_valid}, 32'd0);
    check("rst.instr", instr, 32'h0);
    check("rst.pc", instr_pc, 32'h0);
    check("rst.addr", imem_addr, 32'h0);
    tick(); tick();
    reset = 1'b0;

    // Sequential fetch with decode always ready.
    instr_ready = 1'b1;
    fetch_one("seq0", 32'h0000_0000, 32'h0000_0013);
    fetch_one("seq1", 32'h0000_0004, 32'h0010_0093);
    fetch_one("seq2", 32'h0000_0008, 32'h0020_8133);

    // Backpressure: buffer holds pc 8, no new request.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.req", {31'b0, imem_req}, 32'd0);
      check("bp.valid", {31'b0, instr_valid}, 32'd1);
      check("bp.instr", instr, 32'h0020_8133);
      check("bp.pc", instr_pc, 32'h0000_0008);
      tick();
    end
    instr_ready = 1'b1;
    fetch_one("bp_resume", 32'h0000_000C, 32'h0031_01B3);

    // Redirect while waiting for a response.
    issue("rw", 32'h0000_0010);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check("rw.drain_noreq", {31'b0, imem_req}, 32'd0);
    check("rw.valid0", {31'b0, instr_valid}, 32'd0);
    respond(32'hDEAD_BEEF);
    check("rw.dropped", {31'b0, instr_valid}, 32'd0);
    fetch_one("rw_new", 32'h0000_0100, 32'h0041_8233);

    // Redirect coincident with rvalid in WAIT: data dropped, drain stays for its response.
    issue("rr", 32'h0000_0104);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    redirect_valid = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    check("rr.valid0", {31'b0, instr_valid}, 32'd0);
    check("rr.drain_noreq", {31'b0, imem_req}, 32'd0);
    respond(32'hBAD0_0002);
    check("rr.still0", {31'b0, instr_valid}, 32'd0);
    fetch_one("rr_new", 32'h0000_0200, 32'h0052_82B3);

    // Redirect in REQ with buffer full and ready: misaligned target, consume overridden.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check("ma.req_gated", {31'b0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    check("ma.valid0", {31'b0, instr_valid}, 32'd0);
    fetch_one("ma_new", 32'h0000_0100, 32'h0063_0333);

    // Wraparound of fetch_pc + 4.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_one("wrap_top", 32'hFFFF_FFFC, 32'h0073_83B3);
    fetch_one("wrap_zero", 32'h0000_0000, 32'h0084_0433);

    // Reset in WAIT, late rvalid after release is ignored.
    issue("rs", 32'h0000_0004);
    reset = 1'b1;
    #1;
    check("rs.req", {31'b0, imem_req}, 32'd0);
    check("rs.valid", {31'b0, instr_valid}, 32'd0);
    check("rs.instr", instr, 32'h0);
    check("rs.pc", instr_pc, 32'h0);
    tick();
    reset = 1'b0;
    respond(32'hBAD0_0003);
    check("rs.late_ignored", {31'b0, instr_valid}, 32'd0);
    check("rs.instr_zero", instr, 32'h0);
    fetch_one("rs_new", 32'h0000_0000, 32'h0094_84B3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
